// File: rtl/order_risk_check.sv
// Pre-trade risk stage: checks qty, price band, net position and order rate on each
// handshaked order word, forwards accepted words unchanged through a single output
// register, and reports rejects on a one-cycle side channel.
// Optional feature: define RISK_KILL_SWITCH_EN to add the kill input (reject code 5).
module order_risk_check #(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned BURST      = 8,
  parameter int unsigned REFILL_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [15:0]      cfg_max_qty,
  input  logic [31:0]      cfg_price_lo,
  input  logic [31:0]      cfg_price_hi,
  input  logic [31:0]      cfg_pos_limit,
  output logic             rej_valid,
  output logic [2:0]       rej_code,
  output logic [31:0]      net_pos,
  output logic [31:0]      acc_cnt,
  output logic [31:0]      rej_cnt
`ifdef RISK_KILL_SWITCH_EN
  ,
  input  logic             kill
`endif
);

  localparam int unsigned TokW = $clog2(BURST + 1);
  localparam int unsigned CntW = (REFILL_CYC > 1) ? $clog2(REFILL_CYC) : 1;

  localparam logic [2:0] CodeOk    = 3'd0;
  localparam logic [2:0] CodeQty   = 3'd1;
  localparam logic [2:0] CodePrice = 3'd2;
  localparam logic [2:0] CodePos   = 3'd3;
  localparam logic [2:0] CodeRate  = 3'd4;
  localparam logic [2:0] CodeKill  = 3'd5;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             rej_valid_q, rej_valid_d;
  logic [2:0]       rej_code_q, rej_code_d;
  logic [31:0]      net_pos_q, net_pos_d;
  logic [31:0]      acc_cnt_q, acc_cnt_d;
  logic [31:0]      rej_cnt_q, rej_cnt_d;
  logic [TokW-1:0]  tokens_q, tokens_d;
  logic [CntW-1:0]  refill_cnt_q, refill_cnt_d;

  logic        kill_w;
  logic        hs, accept, reject, refill, pos_bad;
  logic        side;
  logic [15:0] qty;
  logic [31:0] price;
  logic [2:0]  code;
  // 34-bit two's complement so |net_pos +/- qty| never wraps.
  logic [33:0] pos_ext, pos_new, pos_abs;

`ifdef RISK_KILL_SWITCH_EN
  assign kill_w = kill;
`else
  assign kill_w = 1'b0;
`endif

  assign side  = in_data[63];
  assign qty   = in_data[47:32];
  assign price = in_data[31:0];

  assign in_ready = !out_valid_q || out_ready;
  assign hs       = in_valid && in_ready;

  // Risk decision for the word presented this cycle; first failing check wins.
  always_comb begin
    pos_ext = {{2{net_pos_q[31]}}, net_pos_q};
    pos_new = side ? (pos_ext + {18'b0, qty}) : (pos_ext - {18'b0, qty});
    pos_abs = pos_new[33] ? (34'd0 - pos_new) : pos_new;
    pos_bad = pos_abs > {2'b00, cfg_pos_limit};
    code    = CodeOk;
    if (kill_w) begin
      code = CodeKill;
    end else if (qty == 16'd0 || qty > cfg_max_qty) begin
      code = CodeQty;
    end else if (price < cfg_price_lo || price > cfg_price_hi) begin
      code = CodePrice;
    end else if (pos_bad) begin
      code = CodePos;
    end else if (tokens_q == '0) begin
      code = CodeRate;
    end
  end

  assign accept = hs && (code == CodeOk);
  assign reject = hs && (code != CodeOk);
  assign refill = (refill_cnt_q == CntW'(REFILL_CYC - 1));

  // Next-state for output register, reject channel, position, counters and token bucket.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    net_pos_d    = net_pos_q;
    acc_cnt_d    = acc_cnt_q;
    rej_cnt_d    = rej_cnt_q;
    tokens_d     = tokens_q;
    refill_cnt_d = refill ? '0 : refill_cnt_q + 1'b1;
    rej_valid_d  = reject;
    rej_code_d   = reject ? code : CodeOk;

    if (hs) begin
      out_valid_d = accept;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_data_d = in_data;
      net_pos_d  = pos_new[31:0];
      acc_cnt_d  = acc_cnt_q + 32'd1;
    end
    if (reject) begin
      rej_cnt_d = rej_cnt_q + 32'd1;
    end

    // Simultaneous refill and consume cancel out.
    if (accept && !refill) begin
      tokens_d = tokens_q - 1'b1;
    end else if (refill && !accept && tokens_q != TokW'(BURST)) begin
      tokens_d = tokens_q + 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      rej_valid_q  <= 1'b0;
      rej_code_q   <= 3'd0;
      net_pos_q    <= 32'd0;
      acc_cnt_q    <= 32'd0;
      rej_cnt_q    <= 32'd0;
      tokens_q     <= TokW'(BURST);
      refill_cnt_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      rej_valid_q  <= rej_valid_d;
      rej_code_q   <= rej_code_d;
      net_pos_q    <= net_pos_d;
      acc_cnt_q    <= acc_cnt_d;
      rej_cnt_q    <= rej_cnt_d;
      tokens_q     <= tokens_d;
      refill_cnt_q <= refill_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign rej_valid = rej_valid_q;
  assign rej_code  = rej_code_q;
  assign net_pos   = net_pos_q;
  assign acc_cnt   = acc_cnt_q;
  assign rej_cnt   = rej_cnt_q;

endmodule
